// File: rtl/r5p_ifu_pkg.sv
// r5p_ifu_pkg: shared types and helpers for the R5P instruction fetch unit.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package r5p_ifu_pkg;

  localparam int unsigned INS_SIZ_W = 3;

  // one queue entry: fetched word plus its bus error flag
  typedef struct packed {
    logic        err;
    logic [31:0] dat;
  } pfq_ent_t;

  // size in bytes of an instruction from the two LSBs of its low halfword
  function automatic logic [INS_SIZ_W-1:0] opsiz16(input logic [1:0] op);
    return (op == 2'b11) ? 3'd4 : 3'd2;
  endfunction

endpackage

// File: rtl/r5p_ifu_pfq_fifo.sv
// r5p_ifu_pfq_fifo: DEPTH-entry circular word buffer exposing its two head entries.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: none internally; the owner must not push when full or pop more than held.
module r5p_ifu_pfq_fifo
  import r5p_ifu_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH+1)
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  pfq_ent_t         push_dat_i,
  input  logic [1:0]       pop_i,
  output pfq_ent_t         hd0_o,
  output pfq_ent_t         hd1_o,
  output logic [CNT_W-1:0] cnt_o
);

  pfq_ent_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0] rptr_q;
  logic [PTR_W-1:0] rptr_nx;
  logic [CNT_W-1:0] cnt_q;

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + PTR_W'(1);
      rptr_q <= rptr_q + PTR_W'(pop_i);
      cnt_q  <= cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  // storage write; contents need no reset since the count qualifies them
  always_ff @(posedge clk) begin
    if (push_i && !flush_i && !rst) mem_q[wptr_q] <= push_dat_i;
  end

  assign rptr_nx = rptr_q + PTR_W'(1);
  assign hd0_o   = mem_q[rptr_q];
  assign hd1_o   = mem_q[rptr_nx];
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/r5p_ifu_pfq.sv
// r5p_ifu_pfq: prefetch queue and instruction realignment between fetch bus and decoder.
// Latency: one cycle from bus response to ins_vld; outputs are combinational from the queue head.
// Backpressure: ins_rdy=0 holds the instruction; requests stop once occupancy+in-flight reaches DEPTH.
// Compressed (16-bit) instruction support is enabled by defining R5P_IFU_PFQ_C_EN.
module r5p_ifu_pfq
  import r5p_ifu_pkg::*;
#(
  parameter int unsigned     XLEN    = 32,
  parameter int unsigned     DEPTH   = 4,
  parameter logic [XLEN-1:0] IFU_RST = '0,
  parameter logic [XLEN-1:0] IFU_MSK = '1
)(
  input  logic                 clk,
  input  logic                 rst,
  output logic                 ifb_vld,
  output logic [XLEN-1:0]      ifb_adr,
  input  logic                 ifb_rdy,
  input  logic [31:0]          ifb_rdt,
  input  logic                 ifb_err,
  input  logic                 jmp_vld,
  input  logic [XLEN-1:0]      jmp_adr,
  output logic                 ins_vld,
  input  logic                 ins_rdy,
  output logic [31:0]          ins_dat,
  output logic [INS_SIZ_W-1:0] ins_siz,
  output logic [XLEN-1:0]      ins_pc,
  output logic                 ins_err
);

  localparam int unsigned     CNT_W   = $clog2(DEPTH+1);
  localparam logic [XLEN-1:0] ADR_ALN = ~XLEN'(3);
`ifdef R5P_IFU_PFQ_C_EN
  localparam logic [XLEN-1:0] PC_ALN  = ~XLEN'(1);
  localparam logic            HOF_RST = IFU_RST[1];
`else
  localparam logic [XLEN-1:0] PC_ALN  = ADR_ALN;
  localparam logic            HOF_RST = 1'b0;
`endif

  logic [XLEN-1:0]  adr_q, adr_d;   // next fetch address
  logic [XLEN-1:0]  jta_q, jta_d;   // redirect target waiting for a stalled request
  logic             jpn_q, jpn_d;   // stalled request on the bus is stale
  logic             inf_q;          // response expected this cycle
  logic             drp_q;          // that response belongs to a flushed stream
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             hof_q, hof_d;   // halfword offset into the head word
  logic             hof_ins;        // offset after consuming the current instruction
  logic [1:0]       pop_ins;        // words freed by consuming the current instruction
  logic             xfer, push, cns;
  logic [1:0]       pop;
  pfq_ent_t         hd0;
  logic [CNT_W-1:0] cnt;
`ifdef R5P_IFU_PFQ_C_EN
  pfq_ent_t         hd1;
  logic [15:0]      hd1_hi_unused;  // upper half of the second entry never joins the current instruction
  logic [15:0]      lo;
  assign hd1_hi_unused = hd1.dat[31:16];
`else
  pfq_ent_t         hd1_unused;
`endif

  assign ifb_vld = ~rst & ((32'(cnt) + 32'(inf_q)) < DEPTH);
  assign ifb_adr = adr_q;
  assign xfer    = ifb_vld & ifb_rdy;
  assign push    = inf_q & ~drp_q & ~jmp_vld;
  assign cns     = ins_vld & ins_rdy & ~jmp_vld;
  assign pop     = cns ? pop_ins : 2'd0;
  assign ins_pc  = pc_q;

  r5p_ifu_pfq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (jmp_vld),
    .push_i     (push),
    .push_dat_i ('{err: ifb_err, dat: ifb_rdt}),
    .pop_i      (pop),
    .hd0_o      (hd0),
`ifdef R5P_IFU_PFQ_C_EN
    .hd1_o      (hd1),
`else
    .hd1_o      (hd1_unused),
`endif
    .cnt_o      (cnt)
  );

`ifdef R5P_IFU_PFQ_C_EN
  // realign: 16-bit takes one halfword, 32-bit at h=1 borrows the low half of the next word
  always_comb begin
    lo      = hof_q ? hd0.dat[31:16] : hd0.dat[15:0];
    ins_siz = opsiz16(lo[1:0]);
    ins_vld = (cnt != '0);
    ins_dat = {16'h0000, lo};
    ins_err = hd0.err;
    hof_ins = hof_q;
    pop_ins = 2'd1;
    if (ins_siz == 3'd2) begin
      hof_ins = ~hof_q;
      pop_ins = {1'b0, hof_q};
    end else if (!hof_q) begin
      ins_dat = hd0.dat;
    end else begin
      // straddle frees only the head word; the next word's upper half is still pending
      ins_vld = (cnt >= CNT_W'(2));
      ins_dat = {hd1.dat[15:0], lo};
      ins_err = hd0.err | hd1.err;
    end
  end
`else
  // every instruction is a full aligned word
  always_comb begin
    ins_siz = 3'd4;
    ins_vld = (cnt != '0);
    ins_dat = hd0.dat;
    ins_err = hd0.err;
    hof_ins = 1'b0;
    pop_ins = 2'd1;
  end
`endif

  // fetch address sequencing; a redirect during a stalled request waits for its acceptance
  always_comb begin
    adr_d = adr_q;
    jta_d = jta_q;
    jpn_d = jpn_q;
    if (xfer) begin
      adr_d = (jpn_q ? jta_q : adr_q + XLEN'(4)) & IFU_MSK;
      jpn_d = 1'b0;
    end
    if (jmp_vld) begin
      if (ifb_vld && !ifb_rdy) begin
        jpn_d = 1'b1;
        jta_d = jmp_adr & ADR_ALN & IFU_MSK;
      end else begin
        adr_d = jmp_adr & ADR_ALN & IFU_MSK;
        jpn_d = 1'b0;
      end
    end
  end

  // program counter and halfword offset; redirect overrides any consume
  always_comb begin
    pc_d  = pc_q;
    hof_d = hof_q;
    if (jmp_vld) begin
      pc_d  = jmp_adr & PC_ALN;
`ifdef R5P_IFU_PFQ_C_EN
      hof_d = jmp_adr[1];
`else
      hof_d = 1'b0;
`endif
    end else if (cns) begin
      pc_d  = pc_q + XLEN'(ins_siz);
      hof_d = hof_ins;
    end
  end

  // state registers; responses to stale requests are tagged for dropping
  always_ff @(posedge clk) begin
    if (rst) begin
      adr_q <= IFU_RST & ADR_ALN & IFU_MSK;
      jta_q <= '0;
      jpn_q <= 1'b0;
      inf_q <= 1'b0;
      drp_q <= 1'b0;
      pc_q  <= IFU_RST;
      hof_q <= HOF_RST;
    end else begin
      adr_q <= adr_d;
      jta_q <= jta_d;
      jpn_q <= jpn_d;
      inf_q <= xfer;
      drp_q <= xfer & (jmp_vld | jpn_q);
      pc_q  <= pc_d;
      hof_q <= hof_d;
    end
  end

endmodule

// File: tb/tb_r5p_ifu_pfq.sv
// tb_r5p_ifu_pfq: directed table-driven and sequence checks of the prefetch queue.
// Latency: n/a (testbench).
// Backpressure: bus model accepts per ifb_rdy and answers one cycle after each transfer.
module tb_r5p_ifu_pfq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifb_vld;
  logic [31:0] ifb_adr;
  logic        ifb_rdy = 1'b1;
  logic [31:0] ifb_rdt;
  logic        ifb_err;
  logic        jmp_vld = 1'b0;
  logic [31:0] jmp_adr = '0;
  logic        ins_vld;
  logic        ins_rdy = 1'b1;
  logic [31:0] ins_dat;
  logic [2:0]  ins_siz;
  logic [31:0] ins_pc;
  logic        ins_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  r5p_ifu_pfq #(
    .XLEN(32), .DEPTH(4), .IFU_RST(32'h0000_0000), .IFU_MSK(32'hffff_ffff)
  ) dut (
    .clk(clk), .rst(rst),
    .ifb_vld(ifb_vld), .ifb_adr(ifb_adr), .ifb_rdy(ifb_rdy),
    .ifb_rdt(ifb_rdt), .ifb_err(ifb_err),
    .jmp_vld(jmp_vld), .jmp_adr(jmp_adr),
    .ins_vld(ins_vld), .ins_rdy(ins_rdy), .ins_dat(ins_dat),
    .ins_siz(ins_siz), .ins_pc(ins_pc), .ins_err(ins_err)
  );

  // bus memory model: data for the address transferred on the previous edge
  logic [31:0] mem  [256];
  logic        merr [256];
  logic [31:0] rsp_adr;
  always @(posedge clk) rsp_adr <= ifb_adr;
  assign ifb_rdt = mem[rsp_adr[9:2]];
  assign ifb_err = merr[rsp_adr[9:2]];

  // accepted instructions captured by collect()
  logic [31:0] c_pc  [$];
  logic [31:0] c_dat [$];
  logic [31:0] c_siz [$];
  logic        c_err [$];

  typedef struct {
    logic        rdy;
    logic        ifb_vld;
    logic [31:0] adr;
    logic        ins_vld;
    logic [31:0] pc;
  } vec_t;
  vec_t vt [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 32'h0000_0013;
      merr[i] = 1'b0;
    end
  endtask

  // returns #1 into the first cycle with rst low
  task automatic do_reset(input logic rdy);
    rst     = 1'b1;
    ins_rdy = rdy;
    ifb_rdy = 1'b1;
    jmp_vld = 1'b0;
    jmp_adr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic collect(input int ncyc);
    c_pc.delete(); c_dat.delete(); c_siz.delete(); c_err.delete();
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (ins_vld && ins_rdy) begin
        c_pc.push_back(ins_pc);
        c_dat.push_back(ins_dat);
        c_siz.push_back(32'(ins_siz));
        c_err.push_back(ins_err);
      end
      step();
    end
  endtask

  initial begin
    int n;
    // cycle-by-cycle NOP stream with a two-cycle decoder stall (queue reaches full)
    vt[0] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    vt[1] = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    vt[2] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    vt[3] = '{1'b0, 1'b1, 32'h0c, 1'b1, 32'h04};
    vt[4] = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h04};
    vt[5] = '{1'b1, 1'b0, 32'h14, 1'b1, 32'h04};
    vt[6] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h08};
    vt[7] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h0c};
    vt[8] = '{1'b1, 1'b1, 32'h1c, 1'b1, 32'h10};

    fill_nop();

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ifb_vld", 32'(ifb_vld), 32'd0);
    chk("rst_ins_vld", 32'(ins_vld), 32'd0);
    chk("rst_ins_err", 32'(ins_err), 32'd0);
    chk("rst_ifb_adr", ifb_adr, 32'h0);
    chk("rst_ins_pc",  ins_pc,  32'h0);

    do_reset(1'b1);
    for (int k = 0; k < 9; k++) begin
      ins_rdy = vt[k].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d_ifb_vld", k), 32'(ifb_vld), 32'(vt[k].ifb_vld));
      chk($sformatf("vec%0d_ifb_adr", k), ifb_adr, vt[k].adr);
      chk($sformatf("vec%0d_ins_vld", k), 32'(ins_vld), 32'(vt[k].ins_vld));
      chk($sformatf("vec%0d_ins_pc", k), ins_pc, vt[k].pc);
      if (vt[k].ins_vld) begin
        chk($sformatf("vec%0d_ins_siz", k), 32'(ins_siz), 32'd4);
        chk($sformatf("vec%0d_ins_dat", k), ins_dat, 32'h0000_0013);
      end
      step();
    end

    // full queue: decoder stalled, exactly DEPTH transfers, one consume frees one slot
    do_reset(1'b0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ifb_vld && ifb_rdy) n++;
      step();
    end
    chk("full_xfers", 32'(n), 32'd4);
    ins_rdy = 1'b1;
    @(negedge clk);
    chk("full_ifb_vld_lo", 32'(ifb_vld), 32'd0);
    step();
    ins_rdy = 1'b0;
    @(negedge clk);
    chk("full_ifb_vld_back", 32'(ifb_vld), 32'd1);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      if (ifb_vld && ifb_rdy) n++;
      step();
    end
    chk("full_refill_xfers", 32'(n), 32'd1);
    chk("full_pc_after_one", ins_pc, 32'h4);

    // bus error on word 0x8
    fill_nop();
    merr[2] = 1'b1;
    do_reset(1'b1);
    collect(8);
    chk("err_pc2", c_pc[2], 32'h8);
    chk("err_w1",  32'(c_err[1]), 32'd0);
    chk("err_w2",  32'(c_err[2]), 32'd1);
    chk("err_w3",  32'(c_err[3]), 32'd0);

    // redirect to 0x102 in the same cycle as the transfer to 0x10
    fill_nop();
    mem[4]  = 32'h0bad_0013;
    mem[64] = 32'h4505_0013;
    do_reset(1'b1);
    repeat (4) step();
    jmp_vld = 1'b1;
    jmp_adr = 32'h0000_0102;
    @(negedge clk);
    chk("jmp_xfer_adr", ifb_adr, 32'h10);
    chk("jmp_xfer_vld", 32'(ifb_vld), 32'd1);
    step();
    jmp_vld = 1'b0;
    @(negedge clk);
    chk("jmp_ins_vld_after", 32'(ins_vld), 32'd0);
    chk("jmp_next_adr", ifb_adr, 32'h100);
    step();
    collect(4);
`ifdef R5P_IFU_PFQ_C_EN
    chk("jmp_first_pc",  c_pc[0],  32'h102);
    chk("jmp_first_dat", c_dat[0], 32'h0000_4505);
    chk("jmp_first_siz", c_siz[0], 32'd2);
`else
    chk("jmp_first_pc",  c_pc[0],  32'h100);
    chk("jmp_first_dat", c_dat[0], 32'h4505_0013);
    chk("jmp_first_siz", c_siz[0], 32'd4);
`endif

    // redirect while a request is held unaccepted on the bus
    fill_nop();
    mem[8]  = 32'h1111_1113;
    mem[16] = 32'h2222_2213;
    do_reset(1'b1);
    repeat (8) step();
    ifb_rdy = 1'b0;
    @(negedge clk);
    chk("pnd_adr_c8", ifb_adr, 32'h20);
    step();
    jmp_vld = 1'b1;
    jmp_adr = 32'h0000_0040;
    @(negedge clk);
    chk("pnd_adr_jmp", ifb_adr, 32'h20);
    chk("pnd_vld_jmp", 32'(ifb_vld), 32'd1);
    step();
    jmp_vld = 1'b0;
    @(negedge clk);
    chk("pnd_adr_hold", ifb_adr, 32'h20);
    step();
    ifb_rdy = 1'b1;
    @(negedge clk);
    chk("pnd_adr_acc", ifb_adr, 32'h20);
    step();
    @(negedge clk);
    chk("pnd_adr_next", ifb_adr, 32'h40);
    step();
    collect(6);
    chk("pnd_first_pc",  c_pc[0],  32'h40);
    chk("pnd_first_dat", c_dat[0], 32'h2222_2213);

`ifdef R5P_IFU_PFQ_C_EN
    // 16-bit then straddling 32-bit
    fill_nop();
    mem[0] = 32'h0013_4505;
    mem[1] = 32'h0000_0013;
    do_reset(1'b1);
    collect(7);
    chk("c_pc0",  c_pc[0],  32'h0);
    chk("c_siz0", c_siz[0], 32'd2);
    chk("c_dat0", c_dat[0], 32'h0000_4505);
    chk("c_pc1",  c_pc[1],  32'h2);
    chk("c_siz1", c_siz[1], 32'd4);
    chk("c_dat1", c_dat[1], 32'h0013_0013);
    chk("c_pc2",  c_pc[2],  32'h6);
    chk("c_siz2", c_siz[2], 32'd2);
    chk("c_pc3",  c_pc[3],  32'h8);

    // error on the second word of a straddling instruction
    fill_nop();
    mem[1]  = 32'h0013_4505;
    mem[2]  = 32'h0000_0013;
    merr[2] = 1'b1;
    do_reset(1'b1);
    collect(8);
    chk("cerr_pc1",  c_pc[1], 32'h4);
    chk("cerr_e1",   32'(c_err[1]), 32'd0);
    chk("cerr_pc2",  c_pc[2], 32'h6);
    chk("cerr_e2",   32'(c_err[2]), 32'd1);
    chk("cerr_dat2", c_dat[2], 32'h0013_0013);
    chk("cerr_pc3",  c_pc[3], 32'ha);
    chk("cerr_e3",   32'(c_err[3]), 32'd1);
    chk("cerr_e4",   32'(c_err[4]), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
